seq_prio_encoder: RTL

- Parametrised successor to the team's fixed 16-to-4 one-hot encoder with enable.
- Accepts a WIDTH-bit request vector with any number of bits set, not only one-hot.
- Latches the vector, then emits the binary index of every set bit, one per cycle, in priority order, under a valid/ready handshake.
- Used wherever a multi-hot request or status word must be serialised into indices, e.g. interrupt or event draining.

---
 rtl/seq_prio_encoder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_prio_encoder.sv
// Multi-hot request serialiser: latches a request vector and emits the index of each set bit,
// one per handshake, in priority order.
module seq_prio_encoder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDXW      = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [WIDTH-1:0] code,
  input  logic             load,
  output logic             in_ready,
  output logic [IDXW-1:0]  out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic [IDXW:0]    nbits,
  output logic             zero_flag
);

  localparam int unsigned CntW = IDXW + 1;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_pend, w_pend_d;
  logic [IDXW-1:0]  r_hold, w_hold_d;
  logic [CntW-1:0]  r_nbits, w_nbits_d;
  logic             r_zero, w_zero_d;

  logic [IDXW-1:0]  w_idx;
  logic [WIDTH-1:0] w_mask;
  logic             w_single;
  logic             w_load;
  logic             w_beat;

  // Winning index of a vector; the later assignment in the scan has priority.
  function automatic logic [IDXW-1:0] f_pick(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) idx = IDXW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) idx = IDXW'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [CntW-1:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CntW'(v[i]);
    end
    return cnt;
  endfunction

  assign w_idx    = f_pick(r_pend);
  assign w_mask   = WIDTH'(1) << w_idx;
  // Exactly one bit left: the current beat is the final one.
  assign w_single = (r_pend != '0) && ((r_pend & (r_pend - WIDTH'(1))) == '0);

  assign in_ready  = En && (r_state == StIdle);
  assign out_valid = En && (r_state == StDrain);
  assign last      = out_valid && w_single;
  assign out       = (r_state == StDrain) ? w_idx : r_hold;
  assign nbits     = r_nbits;
  assign zero_flag = r_zero;

  assign w_load = load && in_ready;
  assign w_beat = out_valid && out_ready;

  always_comb begin
    w_state_d = r_state;
    w_pend_d  = r_pend;
    w_hold_d  = r_hold;
    w_nbits_d = r_nbits;
    w_zero_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_load) begin
          w_nbits_d = f_popcount(code);
          if (code != '0) begin
            w_pend_d  = code;
            w_state_d = StDrain;
          end else begin
            w_zero_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (w_beat) begin
          w_pend_d = r_pend & ~w_mask;
          w_hold_d = w_idx;
          if (w_single) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_pend  <= '0;
      r_hold  <= '0;
      r_nbits <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pend  <= w_pend_d;
      r_hold  <= w_hold_d;
      r_nbits <= w_nbits_d;
      r_zero  <= w_zero_d;
    end
  end

endmodule
